// File: rtl/inv_aes_sequencer_if.sv
// Handshake and control bundle between the inverse-AES top level and its
// round sequencer. The master side requests runs and supplies key status;
// the slave side (the sequencer) drives the datapath controls.
interface inv_aes_sequencer_if;
  logic       start;
  logic       abort;
  logic       key_ready;
  logic       load_state;
  logic       state_we;
  logic [1:0] op_sel;
  logic [1:0] col_sel;
  logic [3:0] rk_idx;
  logic [3:0] round;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, key_ready,
    input  load_state, state_we, op_sel, col_sel, rk_idx, round, busy, done
  );

  modport slave (
    input  start, abort, key_ready,
    output load_state, state_we, op_sel, col_sel, rk_idx, round, busy, done
  );
endinterface

// File: rtl/inv_aes_sequencer.sv
// Round sequencer for the inverse-AES datapath. A small Moore FSM plus a
// round counter and a column counter walk the shared state register through
// AddRoundKey, InvShiftRows, InvSubBytes and column-serial InvMixColumns,
// selecting round keys from NUM_ROUNDS down to 0.
module inv_aes_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  inv_aes_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEYWAIT = 3'd1,
    S_LOAD    = 3'd2,
    S_ARK     = 3'd3,
    S_ISR     = 3'd4,
    S_ISB     = 3'd5,
    S_IMC     = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [3:0] LP_LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_round;
  logic [3:0] w_round_next;
  logic [1:0] r_col;
  logic [1:0] w_col_next;

  // State, round and column registers; reset clears everything so the
  // decoded outputs drop to zero without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_col   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_round <= w_round_next;
      r_col   <= w_col_next;
    end
  end

  // Next-state logic: abort from any active state returns to IDLE with the
  // counters cleared; otherwise follow the round schedule.
  always_comb begin
    w_state_next = r_state;
    w_round_next = r_round;
    w_col_next   = r_col;
    if (bus.abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
      w_round_next = 4'd0;
      w_col_next   = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            w_state_next = S_KEYWAIT;
          end
        end
        S_KEYWAIT: begin
          if (bus.key_ready) begin
            w_state_next = S_LOAD;
          end
        end
        S_LOAD: begin
          w_round_next = 4'd0;
          w_col_next   = 2'd0;
          w_state_next = S_ARK;
        end
        S_ARK: begin
          if (r_round == LP_LAST_ROUND) begin
            w_state_next = S_DONE;
          end else if (r_round == 4'd0) begin
            // The first round has no InvMixColumns before its shift/sub.
            w_round_next = 4'd1;
            w_state_next = S_ISR;
          end else begin
            w_col_next   = 2'd0;
            w_state_next = S_IMC;
          end
        end
        S_ISR: begin
          w_state_next = S_ISB;
        end
        S_ISB: begin
          w_state_next = S_ARK;
        end
        S_IMC: begin
          if (r_col == 2'd3) begin
            w_col_next   = 2'd0;
            // Saturate rather than wrap; the last round exits via ARK.
            if (r_round < LP_LAST_ROUND) begin
              w_round_next = r_round + 4'd1;
            end
            w_state_next = S_ISR;
          end else begin
            w_col_next = r_col + 2'd1;
          end
        end
        S_DONE: begin
          // A held start keeps us here so it cannot retrigger a run.
          if (!bus.start) begin
            w_state_next = S_IDLE;
            w_round_next = 4'd0;
            w_col_next   = 2'd0;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_round_next = 4'd0;
          w_col_next   = 2'd0;
        end
      endcase
    end
  end

  // Moore output decode from the registered state, round and column only.
  always_comb begin
    bus.load_state = 1'b0;
    bus.state_we   = 1'b0;
    bus.op_sel     = 2'b00;
    bus.col_sel    = 2'b00;
    bus.rk_idx     = 4'd0;
    bus.round      = r_round;
    bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    bus.done       = 1'b0;
    case (r_state)
      S_LOAD: begin
        bus.load_state = 1'b1;
      end
      S_ARK: begin
        bus.state_we = 1'b1;
        bus.op_sel   = 2'b00;
        bus.rk_idx   = LP_LAST_ROUND - r_round;
      end
      S_ISR: begin
        bus.state_we = 1'b1;
        bus.op_sel   = 2'b01;
      end
      S_ISB: begin
        bus.state_we = 1'b1;
        bus.op_sel   = 2'b10;
      end
      S_IMC: begin
        bus.state_we = 1'b1;
        bus.op_sel   = 2'b11;
        bus.col_sel  = r_col;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_inv_aes_sequencer.sv
// Directed bench for the inverse-AES round sequencer: nominal run, key stall,
// held start, abort, asynchronous reset, and a single-round instance.
module tb_inv_aes_sequencer;

  logic clk;
  logic reset_n;

  inv_aes_sequencer_if u_if10 ();
  inv_aes_sequencer_if u_if1 ();

  inv_aes_sequencer #(.NUM_ROUNDS(10)) u_dut10 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if10)
  );

  inv_aes_sequencer #(.NUM_ROUNDS(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Per-run bookkeeping filled by run10.
  int            mism;
  int            we_cnt;
  int            load_cnt;
  int            load_edge;
  int            first_done;
  logic [15:0]   trace [0:99];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {load, we, op, col, rk, round, busy, done}
  function automatic logic [15:0] pack(input logic ld, input logic we, input logic [1:0] op,
                                       input logic [1:0] col, input logic [3:0] rk,
                                       input logic [3:0] rnd, input logic bsy, input logic dn);
    return {ld, we, op, col, rk, rnd, bsy, dn};
  endfunction

  function automatic logic [15:0] obs10();
    return pack(u_if10.load_state, u_if10.state_we, u_if10.op_sel, u_if10.col_sel,
                u_if10.rk_idx, u_if10.round, u_if10.busy, u_if10.done);
  endfunction

  function automatic logic [15:0] obs1();
    return pack(u_if1.load_state, u_if1.state_we, u_if1.op_sel, u_if1.col_sel,
                u_if1.rk_idx, u_if1.round, u_if1.busy, u_if1.done);
  endfunction

  // Hand-derived 10-round schedule, indexed by edges after the last
  // KEYWAIT cycle: 0 KEYWAIT, 1 LOAD, 2 ARK rk10, 3 ISR, 4 ISB, then a
  // 7-cycle block per round (ARK, IMC c0..c3, ISR, ISB), DONE from 69.
  function automatic logic [15:0] exp10(input int kp);
    int j, r, p;
    if (kp <= 0) return pack(0, 0, 2'd0, 2'd0, 4'd0, 4'd0, 1, 0);
    if (kp == 1) return pack(1, 0, 2'd0, 2'd0, 4'd0, 4'd0, 1, 0);
    if (kp == 2) return pack(0, 1, 2'd0, 2'd0, 4'd10, 4'd0, 1, 0);
    if (kp == 3) return pack(0, 1, 2'd1, 2'd0, 4'd0, 4'd1, 1, 0);
    if (kp == 4) return pack(0, 1, 2'd2, 2'd0, 4'd0, 4'd1, 1, 0);
    if (kp >= 69) return pack(0, 0, 2'd0, 2'd0, 4'd0, 4'd10, 0, 1);
    j = kp - 5;
    r = 1 + j / 7;
    p = j % 7;
    if (p == 0) return pack(0, 1, 2'd0, 2'd0, 4'(10 - r), 4'(r), 1, 0);
    if (p <= 4) return pack(0, 1, 2'd3, 2'(p - 1), 4'd0, 4'(r), 1, 0);
    if (p == 5) return pack(0, 1, 2'd1, 2'd0, 4'd0, 4'(r + 1), 1, 0);
    return pack(0, 1, 2'd2, 2'd0, 4'd0, 4'(r + 1), 1, 0);
  endfunction

  // Starts a run on the 10-round instance (entered 1 time unit after a
  // rising edge, DUT idle) and observes edges 0..cycles.
  task automatic run10(input int stall, input int cycles, input bit hold);
    logic [15:0] w;
    mism = 0; we_cnt = 0; load_cnt = 0; load_edge = -1; first_done = -1;
    u_if10.start     = 1'b1;
    u_if10.key_ready = (stall == 0);
    @(posedge clk); #1;
    if (!hold) u_if10.start = 1'b0;
    w = obs10();
    trace[0] = w;
    if (w !== exp10(0 - stall)) mism++;
    for (int k = 1; k <= cycles; k++) begin
      if (k == stall + 1) u_if10.key_ready = 1'b1;
      @(posedge clk); #1;
      w = obs10();
      trace[k] = w;
      if (w !== exp10(k - stall)) begin
        mism++;
        $display("  edge %0d: got %0h expected %0h", k, w, exp10(k - stall));
      end
      if (w[15]) begin load_cnt++; load_edge = k; end
      if (w[14]) we_cnt++;
      if (w[0] && first_done < 0) first_done = k;
    end
  endtask

  int cnt;
  logic [15:0] tbl1 [0:6];

  initial begin
    reset_n          = 1'b0;
    u_if10.start     = 1'b0;
    u_if10.abort     = 1'b0;
    u_if10.key_ready = 1'b1;
    u_if1.start      = 1'b0;
    u_if1.abort      = 1'b0;
    u_if1.key_ready  = 1'b1;
    #1;
    check("reset_outputs_n10", 32'(obs10()), 32'h0);
    check("reset_outputs_n1", 32'(obs1()), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(obs10()), 32'h0);

    // Abort in IDLE blocks a simultaneous start.
    u_if10.start = 1'b1; u_if10.abort = 1'b1;
    @(posedge clk); #1;
    u_if10.start = 1'b0; u_if10.abort = 1'b0;
    check("abort_beats_start_busy", 32'(u_if10.busy), 32'd0);

    // Nominal 10-round run.
    run10(0, 69, 1'b0);
    $display("nominal: mismatched edges=%0d we=%0d loads=%0d done_edge=%0d", mism, we_cnt, load_cnt, first_done);
    check("nominal_trace", 32'(mism), 32'd0);
    check("nominal_we_count", 32'(we_cnt), 32'd67);
    check("nominal_load_count", 32'(load_cnt), 32'd1);
    check("nominal_load_edge", 32'(load_edge), 32'd1);
    check("nominal_done_edge", 32'(first_done), 32'd69);
    check("nominal_ark_rk10", 32'(trace[2]), 32'(pack(0, 1, 2'd0, 2'd0, 4'd10, 4'd0, 1, 0)));
    check("nominal_ark_rk9", 32'(trace[5]), 32'(pack(0, 1, 2'd0, 2'd0, 4'd9, 4'd1, 1, 0)));
    check("nominal_imc_c0", 32'(trace[6]), 32'(pack(0, 1, 2'd3, 2'd0, 4'd0, 4'd1, 1, 0)));
    check("nominal_imc_c3", 32'(trace[9]), 32'(pack(0, 1, 2'd3, 2'd3, 4'd0, 4'd1, 1, 0)));
    check("nominal_isr_r2", 32'(trace[10]), 32'(pack(0, 1, 2'd1, 2'd0, 4'd0, 4'd2, 1, 0)));
    check("nominal_ark_rk0", 32'(trace[68]), 32'(pack(0, 1, 2'd0, 2'd0, 4'd0, 4'd10, 1, 0)));
    @(posedge clk); #1;
    check("nominal_back_to_idle", 32'({u_if10.busy, u_if10.done}), 32'd0);

    // Key stall of 5 cycles.
    run10(5, 74, 1'b0);
    $display("stall: mismatched edges=%0d we=%0d load_edge=%0d done_edge=%0d", mism, we_cnt, load_edge, first_done);
    check("stall_trace", 32'(mism), 32'd0);
    check("stall_load_edge", 32'(load_edge), 32'd6);
    check("stall_done_edge", 32'(first_done), 32'd74);
    check("stall_we_count", 32'(we_cnt), 32'd67);
    @(posedge clk); #1;

    // Held start: stays in DONE, then one drop returns to IDLE with no rerun.
    run10(0, 69, 1'b1);
    check("held_trace", 32'(mism), 32'd0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (u_if10.done && !u_if10.busy) cnt++;
    end
    check("held_stays_done", 32'(cnt), 32'd3);
    u_if10.start = 1'b0;
    @(posedge clk); #1;
    check("held_drop_idle", 32'({u_if10.busy, u_if10.done, u_if10.state_we}), 32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (u_if10.busy || u_if10.done) cnt++;
    end
    check("held_no_second_run", 32'(cnt), 32'd0);

    // Abort during IMC of round 4, column 2.
    run10(0, 29, 1'b0);
    check("abort_at_imc_r4_c2", 32'(trace[29]), 32'(pack(0, 1, 2'd3, 2'd2, 4'd0, 4'd4, 1, 0)));
    u_if10.abort = 1'b1;
    @(posedge clk); #1;
    u_if10.abort = 1'b0;
    check("abort_outputs_zero", 32'(obs10()), 32'h0);
    check("abort_no_done", 32'(first_done), 32'hFFFF_FFFF);
    run10(0, 69, 1'b0);
    check("after_abort_trace", 32'(mism), 32'd0);
    check("after_abort_done_edge", 32'(first_done), 32'd69);
    @(posedge clk); #1;

    // Asynchronous reset during ISB with round 7.
    run10(0, 46, 1'b0);
    check("arst_at_isb_r7", 32'(trace[46]), 32'(pack(0, 1, 2'd2, 2'd0, 4'd0, 4'd7, 1, 0)));
    #3 reset_n = 1'b0;
    #1 check("arst_outputs_immediate", 32'(obs10()), 32'h0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle_after_release", 32'(obs10()), 32'h0);

    // Single-round instance.
    tbl1[0] = pack(0, 0, 2'd0, 2'd0, 4'd0, 4'd0, 1, 0);
    tbl1[1] = pack(1, 0, 2'd0, 2'd0, 4'd0, 4'd0, 1, 0);
    tbl1[2] = pack(0, 1, 2'd0, 2'd0, 4'd1, 4'd0, 1, 0);
    tbl1[3] = pack(0, 1, 2'd1, 2'd0, 4'd0, 4'd1, 1, 0);
    tbl1[4] = pack(0, 1, 2'd2, 2'd0, 4'd0, 4'd1, 1, 0);
    tbl1[5] = pack(0, 1, 2'd0, 2'd0, 4'd0, 4'd1, 1, 0);
    tbl1[6] = pack(0, 0, 2'd0, 2'd0, 4'd0, 4'd1, 0, 1);
    u_if1.start = 1'b1;
    cnt = 0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      u_if1.start = 1'b0;
      $display("n1 edge %0d: outputs %0h", k, obs1());
      if (u_if1.op_sel == 2'b11 && u_if1.state_we) cnt++;
      check($sformatf("n1_edge%0d", k), 32'(obs1()), 32'(tbl1[k]));
    end
    check("n1_no_imc", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    check("n1_idle_after_done", 32'({u_if1.busy, u_if1.done}), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
